act_lut_loader: RTL
===================

// Module: act_lut_loader
// PURPOSE
//  Writer side of the activation-function LUT port. Accepts a host stream of interpolation
//  coefficients over a valid/ready bus, assembles multi-beat {a_coef,b_coef} entries and issues
//  single-cycle writes (write_enable/write_addr/write_data) into one table of the activation LUT.
//  Sits between the host/config DMA and the activation unit; one table (mask) per command.
// PARAMETERS
//  ACT_LUT_DEPTH  4   x-MSB index bits; entries per table = 2**ACT_LUT_DEPTH
//  ACT_MASK_SIZE  4   table-select (mask) bits; upper bits of LUT address
//  ACT_LUT_SIZE   24  entry width = {a_coef (MSBs), b_coef (LSBs)}
//  BUS_WIDTH      16  host beat width; BEATS = ceil(ACT_LUT_SIZE/BUS_WIDTH) beats per entry
// PORTS
//  clk              in   1                        clock, all logic posedge
//  rst_n            in   1                        async active-low reset
//  start            in   1                        begin load of table table_sel (sampled in IDLE only)
//  table_sel        in   ACT_MASK_SIZE            table index, latched on accepted start
//  abort            in   1                        cancel current load, return to IDLE
//  in_valid         in   1                        host beat valid
//  in_ready         out  1                        loader accepts beat (beat taken when valid&&ready)
//  in_data          in   BUS_WIDTH                host beat, entry LS beat first
//  busy             out  1                        high in LOAD/WRITE
//  done             out  1                        1-cycle pulse after last entry written
//  entries_written  out  ACT_LUT_DEPTH+1          entries written in current/last load
//  write_enable     out  1                        LUT write strobe, 1 cycle per entry
//  write_addr       out  ACT_MASK_SIZE+ACT_LUT_DEPTH  {table, entry address}
//  write_data       out  ACT_LUT_SIZE             assembled {a_coef,b_coef}
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (in_ready, busy, done, write_enable, write_addr, write_data,
//   entries_written); beat/index counters and assembly register cleared. All outputs registered.
//  States: IDLE -> (start) LOAD -> (last beat of entry accepted) WRITE -> LOAD | DONE -> IDLE.
//  IDLE: start=1 latches table_sel, clears index, beat count and entries_written; LOAD next cycle.
//   start while busy is ignored (no error, no relatch).
//  LOAD: in_ready=1. Each accepted beat k stored in bits [k*BUS_WIDTH +: BUS_WIDTH]; bits of the
//   final beat above ACT_LUT_SIZE are discarded. in_valid low = stall, no state change.
//  WRITE: in_ready=0; write_enable=1 for exactly this cycle with write_data = assembled entry,
//   write_addr = {table, index ^ (1<<(ACT_LUT_DEPTH-1))} so host sends entries in ascending signed
//   x order (index 0 -> most negative bucket, address 100..0; wraps through 11..1 to 00..0, ends 01..1).
//   entries_written increments on the same edge. If index == 2**ACT_LUT_DEPTH-1 -> DONE, else
//   index++, LOAD. Throughput: BEATS+1 cycles per entry with in_valid held high.
//  DONE: done=1 one cycle, busy=0; IDLE next. entries_written holds 2**ACT_LUT_DEPTH until next start.
//  abort (any state, priority over all): state IDLE next edge, write_enable/in_ready/busy 0 from that
//   edge, partial entry discarded, no done pulse, entries_written keeps count of completed writes.
//   A write visible in the abort cycle itself has already occurred and counts.
//  Simultaneous abort+start in IDLE: abort wins, start ignored.
//  Async reset mid-load: immediate return to reset values; LUT contents undefined for that table.
// TESTING
//  Reset: rst_n=0 mid-LOAD -> all outputs 0 asynchronously, IDLE after release.
//  Full load, defaults, table_sel=4'h3, 16 entries of 2 beats, in_valid constant -> 16 writes,
//   addresses 0x38,0x39..0x3F,0x30..0x37, 3 cycles apart, done pulse once, entries_written=16.
//  Beat assembly: beats 16'hBEEF,16'h12CD -> write_data=24'hCDBEEF (upper byte dropped).
//  Backpressure: in_valid toggled every other cycle -> same writes/data, no duplicated or lost beats.
//  Abort after 5 entries + 1 beat -> no further write_enable, entries_written=5, no done, busy=0.
//  start asserted during LOAD with different table_sel -> ignored; addresses keep original table.

Source files
------------

// File: rtl/act_lut_loader.sv
// Activation LUT writer: assembles multi-beat {a_coef,b_coef} entries from a host
// valid/ready stream and issues one single-cycle write per entry into one table.
module act_lut_loader #(
  parameter int unsigned ACT_LUT_DEPTH = 4,
  parameter int unsigned ACT_MASK_SIZE = 4,
  parameter int unsigned ACT_LUT_SIZE  = 24,
  parameter int unsigned BUS_WIDTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [ACT_MASK_SIZE-1:0]               table_sel,
  input  logic                                   abort,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [BUS_WIDTH-1:0]                   in_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [ACT_LUT_DEPTH:0]                 entries_written,
  output logic                                   write_enable,
  output logic [ACT_MASK_SIZE+ACT_LUT_DEPTH-1:0] write_addr,
  output logic [ACT_LUT_SIZE-1:0]                write_data
);

  localparam int unsigned BEATS  = (ACT_LUT_SIZE + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned ASM_W  = BEATS * BUS_WIDTH;
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ADDR_W = ACT_MASK_SIZE + ACT_LUT_DEPTH;
  localparam int unsigned CNT_W  = ACT_LUT_DEPTH + 1;
  localparam logic [ACT_LUT_DEPTH-1:0] IDX_LAST = '1;
  // Flipping the index MSB maps ascending signed x onto the two's-complement bucket address
  localparam logic [ACT_LUT_DEPTH-1:0] IDX_FLIP = ACT_LUT_DEPTH'(1) << (ACT_LUT_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [ACT_MASK_SIZE-1:0]   table_q, table_d;
  logic [ACT_LUT_DEPTH-1:0]   index_q, index_d;
  logic [BCNT_W-1:0]          beat_q, beat_d;
  logic [ASM_W-1:0]           asm_q, asm_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]          waddr_q, waddr_d;
  logic [ACT_LUT_SIZE-1:0]    wdata_q, wdata_d;
  logic                       in_ready_q, in_ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       we_q, we_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    table_d = table_q;
    index_d = index_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          table_d = table_sel;
          index_d = '0;
          beat_d  = '0;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == BCNT_W'(k)) asm_d[k*BUS_WIDTH +: BUS_WIDTH] = in_data;
          end
          if (beat_q == BCNT_W'(BEATS - 1)) begin
            beat_d  = '0;
            wdata_d = asm_d[ACT_LUT_SIZE-1:0];
            waddr_d = {table_q, index_q ^ IDX_FLIP};
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_WRITE;
          end else begin
            beat_d = beat_q + BCNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (index_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + ACT_LUT_DEPTH'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything; only writes already issued stay counted
    if (abort) begin
      state_d = S_IDLE;
      table_d = table_q;
      index_d = index_q;
      beat_d  = '0;
      asm_d   = asm_q;
      cnt_d   = cnt_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    we_d       = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      table_q    <= '0;
      index_q    <= '0;
      beat_q     <= '0;
      asm_q      <= '0;
      cnt_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      index_q    <= index_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign entries_written = cnt_q;
  assign write_enable    = we_q;
  assign write_addr      = waddr_q;
  assign write_data      = wdata_q;

endmodule
